// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: watches a multiplexed active-low 7-segment bus and
// recovers the hex nibble shown on each digit once it has held steady.
// Optional feature macro: SEG7_BLANK_DETECT_EN (blank digits reported on blank_mask).
module seg7_scan_reader #(
  parameter int NDIG           = 4,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
  output logic              busy,
  output logic              valid,
  output logic [NDIG*4-1:0] value,
  output logic [NDIG-1:0]   err_mask,
`ifdef SEG7_BLANK_DETECT_EN
  output logic [NDIG-1:0]   blank_mask,
`endif
  output logic              timeout
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int ST_W  = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ST_W-1:0]     stab_q, stab_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [NDIG-1:0]     mask_q, mask_d;
  logic [NDIG*4-1:0]   value_q, value_d;
  logic [NDIG-1:0]     err_q, err_d;
  logic                timeout_q, timeout_d;
  logic [6:0]          seg_prev_q, seg_prev_d;
  logic [NDIG-1:0]     sel_prev_q, sel_prev_d;
  logic [NDIG-1:0]     blank_q, blank_d;

  logic [IDX_W-1:0]    sel_idx;
  int                  sel_cnt;
  logic                onehot;
  logic                pair_match;
  logic [4:0]          dec_w;

  // Returns {unknown, nibble}; unknown patterns decode to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b0000011: decode = 5'h0B;
      7'b1000110: decode = 5'h0C;
      7'b0100001: decode = 5'h0D;
      7'b0000110: decode = 5'h0E;
      7'b0001110: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  // Stability counter increment, saturating at the capture threshold.
  function automatic logic [ST_W-1:0] sat_inc(input logic [ST_W-1:0] c);
    if (c >= ST_W'(STABLE_CYCLES)) sat_inc = ST_W'(STABLE_CYCLES);
    else                           sat_inc = c + ST_W'(1);
  endfunction

  assign dec_w      = decode(seg_in);
  assign pair_match = (seg_in == seg_prev_q) && (dig_sel == sel_prev_q);
  assign onehot     = (sel_cnt == 1);

  // Count active strobe bits and locate the selected digit.
  always_comb begin
    sel_cnt = 0;
    sel_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_sel[i]) begin
        sel_cnt = sel_cnt + 1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Next-state logic: read sequencing, stability tracking and digit capture.
  always_comb begin
    state_d    = state_q;
    stab_d     = stab_q;
    to_d       = to_q;
    mask_d     = mask_q;
    value_d    = value_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    seg_prev_d = seg_prev_q;
    sel_prev_d = sel_prev_q;
    blank_d    = blank_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Clearing the previous strobe forces a mismatch on the first
          // SCAN cycle, so that cycle counts as 1.
          mask_d     = '0;
          value_d    = '0;
          err_d      = '0;
          timeout_d  = 1'b0;
          stab_d     = '0;
          to_d       = '0;
          seg_prev_d = '0;
          sel_prev_d = '0;
          blank_d    = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        to_d       = to_q + TO_W'(1);
        seg_prev_d = seg_in;
        sel_prev_d = dig_sel;
        if (onehot) stab_d = pair_match ? sat_inc(stab_q) : ST_W'(1);
        else        stab_d = '0;
        if (onehot && (stab_d == ST_W'(STABLE_CYCLES)) && !mask_q[sel_idx]) begin
          mask_d[sel_idx] = 1'b1;
`ifdef SEG7_BLANK_DETECT_EN
          if (seg_in == 7'b1111111) begin
            value_d[int'(sel_idx)*4 +: 4] = 4'h0;
            err_d[sel_idx]                = 1'b0;
            blank_d[sel_idx]              = 1'b1;
          end else
`endif
          begin
            value_d[int'(sel_idx)*4 +: 4] = dec_w[3:0];
            err_d[sel_idx]                = dec_w[4];
          end
        end
        if (&mask_d) begin
          state_d = DONE;
        end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      stab_q     <= '0;
      to_q       <= '0;
      mask_q     <= '0;
      value_q    <= '0;
      err_q      <= '0;
      timeout_q  <= 1'b0;
      seg_prev_q <= '0;
      sel_prev_q <= '0;
      blank_q    <= '0;
    end else begin
      state_q    <= state_d;
      stab_q     <= stab_d;
      to_q       <= to_d;
      mask_q     <= mask_d;
      value_q    <= value_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      seg_prev_q <= seg_prev_d;
      sel_prev_q <= sel_prev_d;
      blank_q    <= blank_d;
    end
  end

  assign busy     = (state_q == SCAN);
  assign valid    = (state_q == DONE);
  assign value    = value_q;
  assign err_mask = err_q;
  assign timeout  = timeout_q;
`ifdef SEG7_BLANK_DETECT_EN
  assign blank_mask = blank_q;
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed stimulus tables replayed per read,
// a run-length model of the expected result, and a per-cycle compare process.
module tb_seg7_scan_reader;
  localparam int NDIG = 4;
  localparam int ST   = 8;
  localparam int TO   = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  dig_sel = 4'h0;
  logic        busy, valid, timeout;
  logic [15:0] value;
  logic [3:0]  err_mask;
`ifdef SEG7_BLANK_DETECT_EN
  logic [3:0]  blank_mask;
`endif

  seg7_scan_reader #(.NDIG(NDIG), .STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seg_in(seg_in), .dig_sel(dig_sel),
    .busy(busy), .valid(valid), .value(value), .err_mask(err_mask),
`ifdef SEG7_BLANK_DETECT_EN
    .blank_mask(blank_mask),
`endif
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  logic [6:0] dec_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Stimulus tables, indexed by SCAN cycle number after the start pulse.
  logic [6:0] seg_a   [256];
  logic [3:0] sel_a   [256];
  logic       start_a [256];

  int          nchk, nerr;
  int          k_now;
  logic        active;
  int          m_kd;
  logic [15:0] m_val;
  logic [3:0]  m_err, m_blank;
  logic        m_to;

  function automatic logic [6:0] enc(input int n);
    return dec_tab[n];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < 256; k++) begin
      seg_a[k] = 7'h7F; sel_a[k] = 4'h0; start_a[k] = 1'b0;
    end
  endtask

  // Rotate through digits 0..3 from cycle 'off', each held 'hold' cycles.
  task automatic build_rot(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input int hold, input int off);
    for (int k = off; k < 256; k++) begin
      int d;
      d = ((k - off) / hold) % 4;
      sel_a[k] = 4'(1 << d);
      seg_a[k] = (d == 0) ? s0 : (d == 1) ? s1 : (d == 2) ? s2 : s3;
    end
  endtask

  // Model: a digit is captured at the first cycle whose run of identical
  // one-hot (seg, sel) pairs since the start of the read is at least ST long.
  task automatic model_run();
    logic [3:0] cap;
    int run, i, found;
    cap = 4'h0; m_val = '0; m_err = '0; m_blank = '0; m_to = 1'b0; m_kd = TO - 1;
    for (int k = 0; k < TO; k++) begin
      if ($countones(sel_a[k]) == 1) begin
        run = 0;
        for (int j = k; j >= 0; j--) begin
          if (sel_a[j] == sel_a[k] && seg_a[j] == seg_a[k]) run++;
          else break;
        end
        i = $clog2(sel_a[k]);
        if (run >= ST && !cap[i]) begin
          cap[i] = 1'b1;
          found = -1;
          for (int t = 0; t < 16; t++) if (dec_tab[t] == seg_a[k]) found = t;
`ifdef SEG7_BLANK_DETECT_EN
          if (seg_a[k] == 7'h7F) m_blank[i] = 1'b1;
          else
`endif
          if (found < 0) m_err[i] = 1'b1;
          else m_val[i*4 +: 4] = 4'(found);
        end
      end
      if (cap == 4'hF) begin
        m_kd = k;
        break;
      end
      if (k == TO - 1) m_to = 1'b1;
    end
  endtask

  // Per-cycle comparison against the model while a read is being replayed.
  always @(negedge clk) begin
    if (active) begin
      check("busy", busy, k_now <= m_kd);
      check("valid", valid, k_now == m_kd + 1);
      if (k_now > m_kd) begin
        check("value", value, m_val);
        check("err_mask", err_mask, m_err);
        check("timeout", timeout, m_to);
`ifdef SEG7_BLANK_DETECT_EN
        check("blank_mask", blank_mask, m_blank);
`endif
      end
    end
  end

  // Replay the stimulus tables as one read; abort_k >= 0 asserts reset there.
  task automatic run_read(input int abort_k);
    model_run();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= m_kd + 3; k++) begin
      start = start_a[k]; seg_in = seg_a[k]; dig_sel = sel_a[k]; k_now = k;
      if (k == abort_k) begin
        active = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst busy", busy, 0);
        check("rst valid", valid, 0);
        check("rst value", value, 0);
        check("rst err", err_mask, 0);
        check("rst timeout", timeout, 0);
        repeat (3) begin
          @(negedge clk);
          check("rst no valid", valid, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        start = 1'b0; dig_sel = 4'h0;
        return;
      end
      active = 1'b1;
      @(posedge clk); #1;
    end
    active = 1'b0; start = 1'b0; dig_sel = 4'h0; seg_in = 7'h7F;
  endtask

  initial begin
    nchk = 0; nerr = 0; active = 1'b0; k_now = 0; m_kd = 0;
    clear_stim();
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset valid", valid, 0);
    check("reset value", value, 0);
    check("reset err", err_mask, 0);
    check("reset timeout", timeout, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // T1: 3,A,7,F held 8 cycles each.
    clear_stim();
    build_rot(enc(3), enc(10), enc(7), enc(15), 8, 0);
    run_read(-1);
    check("T1 model kd", m_kd, 31);
    check("T1 value", value, 16'hF7A3);
    check("T1 err", err_mask, 4'h0);
    check("T1 timeout", timeout, 0);

    // T2: unknown pattern on digit 2.
    clear_stim();
    build_rot(enc(1), enc(2), 7'b1010101, enc(4), 8, 0);
    run_read(-1);
    check("T2 value", value, 16'h4021);
    check("T2 err", err_mask, 4'b0100);

    // T3: 7-cycle holds never reach the threshold.
    clear_stim();
    build_rot(enc(1), enc(2), enc(3), enc(4), 7, 0);
    run_read(-1);
    check("T3 model kd", m_kd, TO - 1);
    check("T3 value", value, 16'h0000);
    check("T3 err", err_mask, 4'h0);
    check("T3 timeout", timeout, 1);

    // T4: digit 1 shows 5 then 9; the first capture stays.
    clear_stim();
    for (int k = 0; k < 16; k++) begin
      sel_a[k] = 4'b0010;
      seg_a[k] = (k < 8) ? enc(5) : enc(9);
    end
    build_rot(enc(0), enc(9), enc(6), enc(14), 8, 16);
    run_read(-1);
    check("T4 model kd", m_kd, 47);
    check("T4 value", value, 16'hE650);
    check("T4 err", err_mask, 4'h0);

    // T5: reset mid-scan, then a clean read.
    clear_stim();
    build_rot(enc(3), enc(10), enc(7), enc(15), 8, 0);
    run_read(12);
    clear_stim();
    build_rot(enc(8), enc(11), enc(12), enc(13), 8, 0);
    run_read(-1);
    check("T5 value", value, 16'hDCB8);
    check("T5 timeout", timeout, 0);

    // T6: multi-hot strobe, starts during SCAN, blank digit 3.
    clear_stim();
    for (int k = 0; k < 20; k++) begin
      sel_a[k] = 4'b0110; seg_a[k] = enc(8);
    end
    start_a[5] = 1'b1;
    start_a[30] = 1'b1;
    build_rot(enc(9), enc(4), enc(2), 7'h7F, 8, 20);
    run_read(-1);
    check("T6 model kd", m_kd, 51);
    check("T6 value", value, 16'h0249);
`ifdef SEG7_BLANK_DETECT_EN
    check("T6 err", err_mask, 4'b0000);
    check("T6 blank", blank_mask, 4'b1000);
`else
    check("T6 err", err_mask, 4'b1000);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
